// File: rtl/nx_fifo_rd_arb.sv
// Round-robin read scheduler draining N FIFO queues into one consumer.
// Credit-gated, one read per cycle, optional grant hold until end of packet.
module nx_fifo_rd_arb #(
   parameter int N        = 4,
   parameter int CREDITS  = 4,
   parameter bit PKT_LOCK = 1'b1,
   parameter int IDW      = (N > 1) ? $clog2(N) : 1,
   parameter int CW       = $clog2(CREDITS + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enable,
   input  logic           clear,
   input  logic [N-1:0]   q_empty,
   input  logic [N-1:0]   q_last,
   input  logic           cr_ret,
   output logic [N-1:0]   q_ren,
   output logic           rd_vld,
   output logic [IDW-1:0] rd_id,
   output logic [CW-1:0]  credits,
   output logic           locked,
   output logic           credit_err
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] lock_id;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] cand;
   logic           lock;
   logic           found;
   logic           issue;
   logic [CW-1:0]  cnt;

   always_comb begin
      sel   = lock_id;
      cand  = '0;
      found = 1'b0;
      if (lock) begin
         found = !q_empty[lock_id];
      end else begin
         for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % N);
            if (!found && !q_empty[cand]) begin
               found = 1'b1;
               sel   = cand;
            end
         end
      end
   end

   // rst_n is in the gate so q_ren drops the instant reset asserts
   assign issue = rst_n && enable && !clear && (cnt != '0) && found;

   always_comb begin
      q_ren = '0;
      if (issue) q_ren[sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= IDW'(N - 1);
         lock       <= 1'b0;
         lock_id    <= '0;
         cnt        <= CW'(CREDITS);
         rd_vld     <= 1'b0;
         rd_id      <= '0;
         credit_err <= 1'b0;
      end else if (clear) begin
         rr_ptr     <= IDW'(N - 1);
         lock       <= 1'b0;
         cnt        <= CW'(CREDITS);
         rd_vld     <= 1'b0;
         credit_err <= 1'b0;
      end else begin
         rd_vld <= issue;
         if (issue) begin
            rr_ptr <= sel;
            rd_id  <= sel;
            if (PKT_LOCK) begin
               lock <= !q_last[sel];
               if (!q_last[sel]) lock_id <= sel;
            end
         end
         if (issue && !cr_ret) begin
            cnt <= cnt - 1'b1;
         end else if (!issue && cr_ret) begin
            if (cnt == CW'(CREDITS)) credit_err <= 1'b1;
            else cnt <= cnt + 1'b1;
         end
      end
   end

   assign credits = cnt;
   assign locked  = lock;

endmodule

// File: tb/tb_nx_fifo_rd_arb.sv
// Directed bench for nx_fifo_rd_arb: vector table plus hand sequences
// for round-robin order and asynchronous reset mid-packet.
module tb_nx_fifo_rd_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       clear;
   logic [3:0] q_empty;
   logic [3:0] q_last;
   logic       cr_ret;

   logic [3:0] q_ren;
   logic       rd_vld;
   logic [1:0] rd_id;
   logic [2:0] credits;
   logic       locked;
   logic       credit_err;

   logic [3:0] b_ren;
   logic       b_vld;
   logic [1:0] b_id;
   logic [2:0] b_credits;
   logic       b_locked;
   logic       b_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nx_fifo_rd_arb #(.N(4), .CREDITS(4), .PKT_LOCK(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .q_empty(q_empty), .q_last(q_last), .cr_ret(cr_ret),
      .q_ren(q_ren), .rd_vld(rd_vld), .rd_id(rd_id),
      .credits(credits), .locked(locked), .credit_err(credit_err)
   );

   nx_fifo_rd_arb #(.N(4), .CREDITS(4), .PKT_LOCK(1'b0)) u_rr (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .q_empty(q_empty), .q_last(q_last), .cr_ret(cr_ret),
      .q_ren(b_ren), .rd_vld(b_vld), .rd_id(b_id),
      .credits(b_credits), .locked(b_locked), .credit_err(b_err)
   );

   typedef struct {
      logic       en;
      logic       clr;
      logic       cr;
      logic [3:0] qe;
      logic [3:0] ql;
      logic [3:0] ren;
      logic [2:0] cred;
      logic       lk;
      logic       err;
   } vec_t;

   vec_t vt[22];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] oh);
      int r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   initial begin
      // {en, clr, cr, q_empty, q_last, q_ren, credits, locked, credit_err}
      vt[0]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0100, 3'd4, 0, 0};
      vt[1]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0100, 3'd3, 0, 0};
      vt[2]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0100, 3'd2, 0, 0};
      vt[3]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0100, 3'd1, 0, 0};
      vt[4]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0000, 3'd0, 0, 0};
      vt[5]  = '{1, 0, 1, 4'b1011, 4'b1111, 4'b0000, 3'd0, 0, 0};
      vt[6]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0100, 3'd1, 0, 0};
      vt[7]  = '{1, 0, 0, 4'b1011, 4'b1111, 4'b0000, 3'd0, 0, 0};
      vt[8]  = '{1, 1, 0, 4'b1011, 4'b1111, 4'b0000, 3'd0, 0, 0};
      vt[9]  = '{1, 0, 1, 4'b0100, 4'b1101, 4'b0001, 3'd4, 0, 0};
      vt[10] = '{1, 0, 1, 4'b0100, 4'b1101, 4'b0010, 3'd4, 0, 0};
      vt[11] = '{1, 0, 1, 4'b0100, 4'b1101, 4'b0010, 3'd4, 1, 0};
      vt[12] = '{1, 0, 1, 4'b0100, 4'b1111, 4'b0010, 3'd4, 1, 0};
      vt[13] = '{1, 0, 1, 4'b0100, 4'b1111, 4'b1000, 3'd4, 0, 0};
      vt[14] = '{1, 0, 1, 4'b0000, 4'b1110, 4'b0001, 3'd4, 0, 0};
      vt[15] = '{1, 0, 0, 4'b0001, 4'b1110, 4'b0000, 3'd4, 1, 0};
      vt[16] = '{1, 0, 0, 4'b0001, 4'b1110, 4'b0000, 3'd4, 1, 0};
      vt[17] = '{1, 0, 1, 4'b0000, 4'b1111, 4'b0001, 3'd4, 1, 0};
      vt[18] = '{0, 0, 1, 4'b1111, 4'b1111, 4'b0000, 3'd4, 0, 0};
      vt[19] = '{0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd4, 0, 1};
      vt[20] = '{1, 1, 1, 4'b0000, 4'b1111, 4'b0000, 3'd4, 0, 1};
      vt[21] = '{1, 0, 1, 4'b0000, 4'b1111, 4'b0001, 3'd4, 0, 0};

      rst_n   = 1'b0;
      enable  = 1'b1;
      clear   = 1'b0;
      q_empty = 4'b0000;
      q_last  = 4'b1111;
      cr_ret  = 1'b0;
      #12;
      chk("rst_q_ren", int'(q_ren), 0);
      chk("rst_rd_vld", int'(rd_vld), 0);
      chk("rst_rd_id", int'(rd_id), 0);
      chk("rst_credits", int'(credits), 4);
      chk("rst_locked", int'(locked), 0);
      chk("rst_credit_err", int'(credit_err), 0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         enable  = vt[i].en;
         clear   = vt[i].clr;
         cr_ret  = vt[i].cr;
         q_empty = vt[i].qe;
         q_last  = vt[i].ql;
         #1;
         chk($sformatf("v%0d_q_ren", i), int'(q_ren), int'(vt[i].ren));
         chk($sformatf("v%0d_credits", i), int'(credits), int'(vt[i].cred));
         chk($sformatf("v%0d_locked", i), int'(locked), int'(vt[i].lk));
         chk($sformatf("v%0d_err", i), int'(credit_err), int'(vt[i].err));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rd_vld", i), int'(rd_vld), int'(|vt[i].ren));
         if (|vt[i].ren)
            chk($sformatf("v%0d_rd_id", i), int'(rd_id), oh_idx(vt[i].ren));
         @(negedge clk);
      end

      // round-robin order on the unlocked instance, packet hold on the other
      enable = 1'b1;
      clear  = 1'b1;
      cr_ret = 1'b0;
      @(negedge clk);
      clear   = 1'b0;
      cr_ret  = 1'b1;
      q_empty = 4'b0000;
      q_last  = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] exp_rr;
         exp_rr = 4'b0001 << (i % 4);
         #1;
         chk($sformatf("rr%0d_q_ren", i), int'(b_ren), int'(exp_rr));
         chk($sformatf("rr%0d_locked", i), int'(b_locked), 0);
         chk($sformatf("pl%0d_q_ren", i), int'(q_ren), 1);
         @(posedge clk);
         #1;
         chk($sformatf("rr%0d_rd_id", i), int'(b_id), i % 4);
         chk($sformatf("rr%0d_rd_vld", i), int'(b_vld), 1);
         chk($sformatf("pl%0d_locked", i), int'(locked), 1);
         @(negedge clk);
      end

      // one more read without credit return, then async reset mid-packet
      cr_ret = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_rd_vld", int'(rd_vld), 1);
      chk("pre_rst_locked", int'(locked), 1);
      chk("pre_rst_credits", int'(credits), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_q_ren", int'(q_ren), 0);
      chk("async_rd_vld", int'(rd_vld), 0);
      chk("async_locked", int'(locked), 0);
      chk("async_credits", int'(credits), 4);
      chk("async_rd_id", int'(rd_id), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nx_fifo_rd_arb.md
Name: nx_fifo_rd_arb

Overview:
Round-robin read scheduler that drains N independent nx_fifo_ctrl-managed queues into one shared downstream consumer.
- Issues at most one read-enable per cycle, to exactly one non-empty queue.
- Gates every read on a downstream credit counter.
- Optionally holds the grant on one queue until the end of a packet.
- Sits between the per-queue FIFO controllers and the shared read-data mux or egress stage.

Parameters:
N, 4, number of queues arbitrated (2..16)
CREDITS, 4, downstream buffer slots; initial and maximum credit count (1..15)
PKT_LOCK, 1, 1 = hold grant on a queue until a read with q_last=1; 0 = per-entry arbitration
IDW, $clog2(N) (min 1), width of queue id outputs
CW, $clog2(CREDITS+1), width of credit counter

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  arbitration enable; 0 = issue no reads
clear  input  1  synchronous soft reset of arbiter state
q_empty  input  N  per-queue empty flag from FIFO controllers
q_last  input  N  per-queue flag: head entry is last of packet; valid only when q_empty[i]=0
cr_ret  input  1  one credit returned by downstream (pulse, one per cycle max)
q_ren  output  N  one-hot read enable to queue FIFO controllers (combinational)
rd_vld  output  1  registered: read data from granted queue valid this cycle
rd_id  output  IDW  registered: queue index of rd_vld data
credits  output  CW  current credit count
locked  output  1  packet lock active
credit_err  output  1  sticky: credit returned while count already at CREDITS

Behaviour:
- Reset (rst_n=0, async): rr_ptr=N-1, lock=0, lock_id=0, credit cnt=CREDITS, rd_vld=0, rd_id=0, credit_err=0. q_ren=0 whenever rst_n=0.
- Eligible: issue possible when enable=1, clear=0, credits>0.
- Unlocked selection: first i in cyclic order rr_ptr+1, rr_ptr+2, ..., rr_ptr with q_empty[i]=0.
- Locked selection: only lock_id; if q_empty[lock_id]=1, no read this cycle (stall, no grant to others).
- q_ren[sel]=1 in the same cycle as the decision. q_ren is driven from registered state plus q_empty, q_last, enable, clear and credits only; there is no path from cr_ret to q_ren.
- Guarantee: q_ren[i] is never asserted while q_empty[i]=1, so FIFO underflow is impossible by construction.
- On issue to queue s, next cycle:
  - rr_ptr=s.
  - rd_vld=1, rd_id=s. One-cycle latency matches the registered FIFO read data.
  - If PKT_LOCK=1: lock=1 and lock_id=s when q_last[s]=0; lock=0 when q_last[s]=1.
- No issue: rd_vld=0 next cycle; rr_ptr and lock unchanged.
- Credits: next = cnt − issue + cr_ret.
  - Simultaneous issue and cr_ret: count unchanged.
  - cr_ret with cnt=CREDITS and no issue: count stays CREDITS and credit_err=1 (sticky).
  - Underflow of the counter is impossible because issue requires cnt>0.
- clear=1 (synchronous):
  - Takes priority over issue; no q_ren that cycle.
  - Next state: rr_ptr=N-1, lock=0, cnt=CREDITS, credit_err=0, rd_vld=0.
  - cr_ret is ignored that cycle.
- enable=0: no issue; state holds. Lock is retained across enable deassertion.
- Reset mid-packet: lock dropped and credits restored. The FIFO controllers are reset by the same rst_n.
- PKT_LOCK=0: lock and locked are constant 0.

Test Plan:
- N=4, all queues non-empty, credits plentiful (cr_ret pulsed each cycle), PKT_LOCK=0 -> q_ren sequence 0001, 0010, 0100, 1000, 0001; rd_id 0,1,2,3 one cycle later.
- CREDITS=4, no cr_ret, queue 2 always non-empty -> exactly 4 reads issued, credits 4→0, then q_ren=0 until cr_ret; one cr_ret -> exactly one further read.
- PKT_LOCK=1, queue1 head q_last=0,0,1; queues 0 and 3 also non-empty -> three consecutive grants to q1; locked=1 through the first two; next grant goes to q3.
- Locked on q0, q0 goes empty while q1 non-empty -> q_ren=0 and locked=1 held; q0 refills -> grant resumes to q0.
- cr_ret pulsed with credits=CREDITS and no reads -> credits stay 4 and credit_err=1; then clear=1 -> credit_err=0, rr_ptr reset (next grant to lowest non-empty queue).
- Assert rst_n=0 asynchronously mid-packet with lock=1 -> q_ren=0, rd_vld=0, locked=0, credits=CREDITS immediately, without waiting for a clock edge.
